// File: rtl/e_out_port_alloc_ctrl_if.sv
// Request/handshake bundle between the N/S/W/L input buffers, the east link and
// the east-port allocator. The allocator connects through the slave modport.
interface e_out_port_alloc_ctrl_if;
  logic [2:0] n_nexthop_addr_i;
  logic [2:0] s_nexthop_addr_i;
  logic [2:0] w_nexthop_addr_i;
  logic [2:0] l_nexthop_addr_i;
  logic [3:0] in_valid_i;
  logic [3:0] in_tail_i;
  logic       e_out_ready_i;
  logic [3:0] in_ready_o;
  logic       e_out_valid_o;
  logic [2:0] cs_sel_o;
  logic [3:0] grant_o;
  logic       change_order_o;
  logic       err_timeout_o;
  logic       busy_o;

  modport master (
    output n_nexthop_addr_i, s_nexthop_addr_i, w_nexthop_addr_i, l_nexthop_addr_i,
    output in_valid_i, in_tail_i, e_out_ready_i,
    input  in_ready_o, e_out_valid_o, cs_sel_o, grant_o,
    input  change_order_o, err_timeout_o, busy_o
  );

  modport slave (
    input  n_nexthop_addr_i, s_nexthop_addr_i, w_nexthop_addr_i, l_nexthop_addr_i,
    input  in_valid_i, in_tail_i, e_out_ready_i,
    output in_ready_o, e_out_valid_o, cs_sel_o, grant_o,
    output change_order_o, err_timeout_o, busy_o
  );
endinterface

// File: rtl/e_out_port_alloc_ctrl.sv
// Wormhole allocator for the east output port: round-robin packet arbitration
// across N/S/W/L, crossbar lock until the tail flit, and a stall watchdog.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner; pick a winner among inputs whose next hop is east
//   LOCK  | owner holds the crossbar until its tail transfers or watchdog
module e_out_port_alloc_ctrl #(
  parameter logic [2:0] EAST_ADDR = 3'b100,
  parameter int         TIMEOUT   = 32,
  parameter int         CNT_W     = 6
) (
  input logic                clk,
  input logic                reset,
  e_out_port_alloc_ctrl_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  localparam bit             WDOG_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] STALL_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             change_q, change_d;
  logic             err_q, err_d;

  // Internal index order is 0=N 1=S 2=W 3=L; port vectors use [3]=N ... [0]=L.
  logic [3:0] desire;
  logic [1:0] winner;
  logic       any_desire;
  logic [1:0] own_bit;
  logic       fire;
  logic       tail_fire;
  logic       timeout_hit;
  logic       release_pkt;

  assign desire[0] = bus.in_valid_i[3] & (bus.n_nexthop_addr_i == EAST_ADDR);
  assign desire[1] = bus.in_valid_i[2] & (bus.s_nexthop_addr_i == EAST_ADDR);
  assign desire[2] = bus.in_valid_i[1] & (bus.w_nexthop_addr_i == EAST_ADDR);
  assign desire[3] = bus.in_valid_i[0] & (bus.l_nexthop_addr_i == EAST_ADDR);

  // Scan farthest offset first so the closest requester to rr_ptr overwrites.
  always_comb begin
    logic [1:0] idx;
    idx        = '0;
    winner     = rr_ptr_q;
    any_desire = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr_q + 2'(k);
      if (desire[idx]) begin
        winner     = idx;
        any_desire = 1'b1;
      end
    end
  end

  assign own_bit     = 2'd3 - owner_q;
  assign fire        = (state_q == ST_LOCK) & bus.in_valid_i[own_bit] & bus.e_out_ready_i;
  assign tail_fire   = fire & bus.in_tail_i[own_bit];
  assign timeout_hit = WDOG_EN & (state_q == ST_LOCK) & ~fire & (stall_q == STALL_LAST);
  assign release_pkt = tail_fire | timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      stall_q  <= '0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      stall_q  <= stall_d;
      change_q <= change_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    stall_d  = stall_q;
    change_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_desire) begin
          state_d = ST_LOCK;
          owner_d = winner;
          stall_d = '0;
        end
      end
      ST_LOCK: begin
        if (release_pkt) begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner_q + 2'd1;
          stall_d  = '0;
          change_d = 1'b1;
          err_d    = timeout_hit;
        end else if (fire) begin
          stall_d = '0;
        end else if (stall_q != '1) begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.grant_o    = '0;
    bus.cs_sel_o   = 3'b000;
    bus.in_ready_o = '0;
    if (state_q == ST_LOCK) begin
      bus.grant_o[own_bit] = 1'b1;
      case (owner_q)
        2'd0:    bus.cs_sel_o = 3'b001;
        2'd1:    bus.cs_sel_o = 3'b010;
        2'd2:    bus.cs_sel_o = 3'b011;
        default: bus.cs_sel_o = 3'b101;
      endcase
    end
    if (fire) bus.in_ready_o[own_bit] = 1'b1;
    bus.e_out_valid_o  = fire;
    bus.busy_o         = (state_q == ST_LOCK);
    bus.change_order_o = change_q;
    bus.err_timeout_o  = err_q;
  end

endmodule

// File: tb/tb_e_out_port_alloc_ctrl.sv
// Directed bench for the east-port allocator: arbitration order, backpressure,
// address filtering, watchdog release and mid-packet reset.
module tb_e_out_port_alloc_ctrl;

  localparam logic [2:0] EAST = 3'b100;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  e_out_port_alloc_ctrl_if bus ();

  e_out_port_alloc_ctrl #(
    .EAST_ADDR (EAST),
    .TIMEOUT   (4),
    .CNT_W     (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] t, input logic rdy);
    bus.in_valid_i    = v;
    bus.in_tail_i     = t;
    bus.e_out_ready_i = rdy;
  endtask

  task automatic set_addr(input logic [2:0] an, input logic [2:0] as,
                          input logic [2:0] aw, input logic [2:0] al);
    bus.n_nexthop_addr_i = an;
    bus.s_nexthop_addr_i = as;
    bus.w_nexthop_addr_i = aw;
    bus.l_nexthop_addr_i = al;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] rr_exp [5];
    int         pulses;
    rr_exp[0] = 4'b1000;
    rr_exp[1] = 4'b0100;
    rr_exp[2] = 4'b0010;
    rr_exp[3] = 4'b0001;
    rr_exp[4] = 4'b1000;
    n_tests = 0;
    n_fail  = 0;
    pulses  = 0;

    // reset
    reset = 1'b1;
    set_addr(3'b000, 3'b000, 3'b000, 3'b000);
    drive(4'b0000, 4'b0000, 1'b1);
    repeat (2) cyc();
    check("rst_grant", 32'(bus.grant_o), 32'h0);
    check("rst_cs", 32'(bus.cs_sel_o), 32'h0);
    check("rst_busy", 32'(bus.busy_o), 32'h0);
    check("rst_chg", 32'(bus.change_order_o), 32'h0);
    check("rst_err", 32'(bus.err_timeout_o), 32'h0);
    reset = 1'b0;
    cyc();
    check("idle_ready", 32'(bus.in_ready_o), 32'h0);
    check("idle_valid", 32'(bus.e_out_valid_o), 32'h0);

    // all four request, single-flit packets
    set_addr(EAST, EAST, EAST, EAST);
    drive(4'b1111, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rr_grant", 32'(bus.grant_o), 32'(rr_exp[i]));
      check("rr_ready", 32'(bus.in_ready_o), 32'(rr_exp[i]));
      cyc();
      check("rr_bubble", 32'(bus.busy_o), 32'h0);
      pulses += int'(bus.change_order_o);
    end
    check("rr_pulses", 32'(pulses), 32'd5);
    drive(4'b0000, 4'b0000, 1'b1);

    // filtering: N heads elsewhere, only L wants east
    set_addr(3'b001, EAST, EAST, EAST);
    drive(4'b1001, 4'b1001, 1'b1);
    cyc();
    check("flt_grant", 32'(bus.grant_o), 32'h1);
    check("flt_cs", 32'(bus.cs_sel_o), 32'h5);
    check("flt_ready", 32'(bus.in_ready_o), 32'h1);
    cyc();
    check("flt_chg", 32'(bus.change_order_o), 32'h1);
    drive(4'b0000, 4'b0000, 1'b1);
    set_addr(EAST, EAST, EAST, EAST);

    // single W, 3-flit packet
    drive(4'b0010, 4'b0000, 1'b1);
    #1;
    check("w_pre_grant", 32'(bus.grant_o), 32'h0);
    cyc();
    check("w_grant", 32'(bus.grant_o), 32'h2);
    check("w_cs", 32'(bus.cs_sel_o), 32'h3);
    check("w_valid", 32'(bus.e_out_valid_o), 32'h1);
    check("w_ready", 32'(bus.in_ready_o), 32'h2);
    cyc();
    check("w_busy", 32'(bus.busy_o), 32'h1);
    check("w_no_chg", 32'(bus.change_order_o), 32'h0);
    cyc();
    drive(4'b0010, 4'b0010, 1'b1);
    #1;
    check("w_tail_ready", 32'(bus.in_ready_o), 32'h2);
    cyc();
    check("w_chg", 32'(bus.change_order_o), 32'h1);
    check("w_rel_grant", 32'(bus.grant_o), 32'h0);
    check("w_rel_busy", 32'(bus.busy_o), 32'h0);
    drive(4'b0000, 4'b0000, 1'b1);

    // pointer now at L
    drive(4'b1111, 4'b1111, 1'b1);
    cyc();
    check("ptr3_grant", 32'(bus.grant_o), 32'h1);
    cyc();
    drive(4'b0000, 4'b0000, 1'b1);

    // backpressure on S, 2-flit packet
    drive(4'b0100, 4'b0000, 1'b1);
    cyc();
    check("bp_grant", 32'(bus.grant_o), 32'h4);
    check("bp_cs", 32'(bus.cs_sel_o), 32'h2);
    check("bp_ready0", 32'(bus.in_ready_o), 32'h4);
    cyc();
    drive(4'b0100, 4'b0100, 1'b0);
    #1;
    check("bp_ready1", 32'(bus.in_ready_o), 32'h0);
    check("bp_valid1", 32'(bus.e_out_valid_o), 32'h0);
    cyc();
    check("bp_busy2", 32'(bus.busy_o), 32'h1);
    check("bp_chg2", 32'(bus.change_order_o), 32'h0);
    check("bp_ready2", 32'(bus.in_ready_o), 32'h0);
    cyc();
    drive(4'b0100, 4'b0100, 1'b1);
    #1;
    check("bp_ready3", 32'(bus.in_ready_o), 32'h4);
    check("bp_valid3", 32'(bus.e_out_valid_o), 32'h1);
    cyc();
    check("bp_chg", 32'(bus.change_order_o), 32'h1);
    check("bp_rel_busy", 32'(bus.busy_o), 32'h0);
    drive(4'b0000, 4'b0000, 1'b1);

    // watchdog: L granted then its valid drops
    drive(4'b0001, 4'b0000, 1'b1);
    cyc();
    check("wd_grant", 32'(bus.grant_o), 32'h1);
    drive(4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("wd_busy", 32'(bus.busy_o), 32'h1);
      check("wd_err_early", 32'(bus.err_timeout_o), 32'h0);
    end
    cyc();
    check("wd_err", 32'(bus.err_timeout_o), 32'h1);
    check("wd_chg", 32'(bus.change_order_o), 32'h1);
    check("wd_busy_rel", 32'(bus.busy_o), 32'h0);
    drive(4'b1111, 4'b1111, 1'b1);
    cyc();
    check("wd_ptr_grant", 32'(bus.grant_o), 32'h8);
    check("wd_err_clear", 32'(bus.err_timeout_o), 32'h0);
    cyc();
    drive(4'b0000, 4'b0000, 1'b1);

    // reset during second flit of an N packet
    drive(4'b1000, 4'b0000, 1'b1);
    cyc();
    check("mr_grant", 32'(bus.grant_o), 32'h8);
    cyc();
    reset = 1'b1;
    cyc();
    check("mr_grant0", 32'(bus.grant_o), 32'h0);
    check("mr_busy0", 32'(bus.busy_o), 32'h0);
    check("mr_chg0", 32'(bus.change_order_o), 32'h0);
    reset = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1);
    cyc();
    check("mr_first_n", 32'(bus.grant_o), 32'h8);
    cyc();
    drive(4'b0000, 4'b0000, 1'b1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
